// File: rtl/hazard_pkg.sv
// Shared types and instruction field positions for the hazard sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } hz_state_e;

  // Register-specifier fields of a 16-bit WISC-SP13 instruction
  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;

  function automatic logic [2:0] get_rs(input logic [15:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [2:0] get_rt(input logic [15:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle: hazard inputs in, stage write enables out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      IFIDInstr;
  logic             IFIDUsesRs;
  logic             IFIDUsesRt;
  logic             IDEXMemRead;
  logic             IDEXWriteToReg;
  logic [2:0]       IDEXRd;
  logic             branchTaken;
  logic             memBusy;
  logic             memDone;
  logic             clrCount;
  logic             pcWrite;
  logic             ifidWrite;
  logic             idexWrite;
  logic             xmWrite;
  logic             mwWrite;
  logic             flushIFID;
  logic             bubbleIDEX;
  logic             err;
  logic [CNT_W-1:0] stallCount;

  // Pipeline / environment side
  modport master (
    output IFIDInstr, IFIDUsesRs, IFIDUsesRt, IDEXMemRead, IDEXWriteToReg,
           IDEXRd, branchTaken, memBusy, memDone, clrCount,
    input  pcWrite, ifidWrite, idexWrite, xmWrite, mwWrite,
           flushIFID, bubbleIDEX, err, stallCount
  );

  // Hazard controller side
  modport slave (
    input  IFIDInstr, IFIDUsesRs, IFIDUsesRt, IDEXMemRead, IDEXWriteToReg,
           IDEXRd, branchTaken, memBusy, memDone, clrCount,
    output pcWrite, ifidWrite, idexWrite, xmWrite, mwWrite,
           flushIFID, bubbleIDEX, err, stallCount
  );
endinterface

// File: rtl/hazard_cmp.sv
// Load-use detector: a load in EX whose destination is read by decode.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [15:0] instr_i,
  input  logic        uses_rs_i,
  input  logic        uses_rt_i,
  input  logic        mem_read_i,
  input  logic        wr_reg_i,
  input  logic [2:0]  rd_i,
  output logic        lu_o
);
  logic [2:0] rs, rt;
  logic       unused_fields;

  assign rs = get_rs(instr_i);
  assign rt = get_rt(instr_i);
  // Opcode and immediate bits play no part in the compare
  assign unused_fields = ^{instr_i[15:11], instr_i[4:0]};

  // Both qualifiers are required: a load that does not write back cannot hazard
  assign lu_o = mem_read_i & wr_reg_i &
                ((uses_rs_i & (rd_i == rs)) | (uses_rt_i & (rd_i == rt)));
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer: load-use bubble, branch flush, memory wait with
// timeout watchdog, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  hz_state_e          state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu;
  // {pc, ifid, idex, xm, mw} before reset gating
  logic [4:0]         en;
  logic               flush, bubble;

  hazard_cmp u_cmp (
    .instr_i    (bus.IFIDInstr),
    .uses_rs_i  (bus.IFIDUsesRs),
    .uses_rt_i  (bus.IFIDUsesRt),
    .mem_read_i (bus.IDEXMemRead),
    .wr_reg_i   (bus.IDEXWriteToReg),
    .rd_i       (bus.IDEXRd),
    .lu_o       (lu)
  );

  // State and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state and Mealy enables; priority memBusy > branchTaken > lu
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    en      = 5'b11111;
    flush   = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      RUN, LU_STALL: begin
        if (bus.memBusy) begin
          en      = 5'b00000;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (bus.branchTaken) begin
          // Enables stay high so the PC takes the redirect target
          flush   = 1'b1;
          bubble  = 1'b1;
          state_d = RUN;
        end else if (state_q == RUN && lu) begin
          // ID/EX gets a bubble, so the hazard is gone next cycle
          en      = 5'b00111;
          bubble  = 1'b1;
          state_d = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        // EX is frozen; a branch here is re-presented after the wait
        en = 5'b00000;
        if (bus.memDone) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERR: en = 5'b00000;
    endcase
  end

  // Stall counter next value: clear beats increment, saturate at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clrCount)
      cnt_d = '0;
    else if (!en[4] && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.pcWrite    = en[4] & ~rst;
  assign bus.ifidWrite  = en[3] & ~rst;
  assign bus.idexWrite  = en[2] & ~rst;
  assign bus.xmWrite    = en[1] & ~rst;
  assign bus.mwWrite    = en[0] & ~rst;
  assign bus.flushIFID  = flush  & ~rst;
  assign bus.bubbleIDEX = bubble & ~rst;
  assign bus.err        = (state_q == ERR);
  assign bus.stallCount = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MAX_WAIT = 4 and a 4-bit stall counter.
`timescale 1ns/100ps
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  hazard_ctrl_if #(.CNT_W(4)) bus ();
  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // {pc, ifid, idex, xm, mw, flush, bubble}
  logic [6:0] en;
  assign en = {bus.pcWrite, bus.ifidWrite, bus.idexWrite, bus.xmWrite,
               bus.mwWrite, bus.flushIFID, bus.bubbleIDEX};

  task automatic idle();
    bus.IFIDInstr = 16'h0000; bus.IFIDUsesRs = 1'b0; bus.IFIDUsesRt = 1'b0;
    bus.IDEXMemRead = 1'b0; bus.IDEXWriteToReg = 1'b0; bus.IDEXRd = 3'd0;
    bus.branchTaken = 1'b0; bus.memBusy = 1'b0; bus.memDone = 1'b0;
    bus.clrCount = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Load in EX writes r3, decode reads Rs = r3
  task automatic set_lu();
    bus.IFIDInstr = 16'h0300; bus.IFIDUsesRs = 1'b1;
    bus.IDEXMemRead = 1'b1; bus.IDEXWriteToReg = 1'b1; bus.IDEXRd = 3'd3;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); #2;
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL rst_en: got %b want %b", en, 7'b0000000); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    checks++; if (bus.stallCount !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", bus.stallCount); end
    tick(); rst = 1'b0; #1;
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL run_idle_en: got %b want %b", en, 7'b1111100); end
  endtask

  task automatic test_load_use();
    tick(); set_lu(); #1;
    checks++; if (en !== 7'b0011101) begin errors++; $display("FAIL lu_en: got %b want %b", en, 7'b0011101); end
    tick(); // LU_STALL, hazard inputs unchanged but not re-evaluated
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL lu_stall_en: got %b want %b", en, 7'b1111100); end
    checks++; if (bus.stallCount !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", bus.stallCount); end
    idle();
    tick();
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL lu_after_en: got %b want %b", en, 7'b1111100); end
    checks++; if (bus.stallCount !== 4'd1) begin errors++; $display("FAIL lu_after_cnt: got %0d want 1", bus.stallCount); end
    // Rt path and qualifiers, combinational only within one cycle
    bus.IFIDInstr = 16'h0060; bus.IFIDUsesRt = 1'b1;
    bus.IDEXMemRead = 1'b1; bus.IDEXWriteToReg = 1'b1; bus.IDEXRd = 3'd3; #1;
    checks++; if (en !== 7'b0011101) begin errors++; $display("FAIL lu_rt_en: got %b want %b", en, 7'b0011101); end
    bus.IFIDUsesRt = 1'b0; #1;
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL lu_rt_unused_en: got %b want %b", en, 7'b1111100); end
    bus.IFIDUsesRt = 1'b1; bus.IDEXWriteToReg = 1'b0; #1;
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL lu_nowr_en: got %b want %b", en, 7'b1111100); end
    bus.IDEXWriteToReg = 1'b1; bus.IDEXRd = 3'd4; #1;
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL lu_rd_miss_en: got %b want %b", en, 7'b1111100); end
    idle();
  endtask

  task automatic test_priority();
    tick(); set_lu(); bus.branchTaken = 1'b1; #1;
    checks++; if (en !== 7'b1111111) begin errors++; $display("FAIL br_lu_en: got %b want %b", en, 7'b1111111); end
    tick(); bus.branchTaken = 1'b0; #1; // still RUN: lu alone stalls again
    checks++; if (en !== 7'b0011101) begin errors++; $display("FAIL br_state_run: got %b want %b", en, 7'b0011101); end
    checks++; if (bus.stallCount !== 4'd1) begin errors++; $display("FAIL br_cnt: got %0d want 1", bus.stallCount); end
    idle();
  endtask

  task automatic test_mem_wait();
    tick(); bus.clrCount = 1'b1;
    tick(); bus.clrCount = 1'b0;
    checks++; if (bus.stallCount !== 4'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", bus.stallCount); end
    bus.memBusy = 1'b1; #1;
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL mem_busy_en: got %b want %b", en, 7'b0000000); end
    tick(); bus.memBusy = 1'b0; bus.branchTaken = 1'b1; #1;
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL mem_br_ignored: got %b want %b", en, 7'b0000000); end
    bus.branchTaken = 1'b0;
    tick();
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL mem_w2_en: got %b want %b", en, 7'b0000000); end
    tick();
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL mem_w3_en: got %b want %b", en, 7'b0000000); end
    tick(); bus.memDone = 1'b1; #1; // 4th wait cycle, at the limit
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL mem_w4_en: got %b want %b", en, 7'b0000000); end
    tick(); bus.memDone = 1'b0; #1;
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL mem_done_en: got %b want %b", en, 7'b1111100); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mem_done_err: got %b want 0", bus.err); end
    checks++; if (bus.stallCount !== 4'd5) begin errors++; $display("FAIL mem_cnt: got %0d want 5", bus.stallCount); end
  endtask

  task automatic test_lu_then_mem();
    tick(); set_lu();
    tick(); idle(); bus.memBusy = 1'b1; #1;
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL lus_mem_en: got %b want %b", en, 7'b0000000); end
    tick(); bus.memBusy = 1'b0; bus.memDone = 1'b1; #1;
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL lus_wait_en: got %b want %b", en, 7'b0000000); end
    tick(); bus.memDone = 1'b0; #1;
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL lus_back_en: got %b want %b", en, 7'b1111100); end
    checks++; if (bus.stallCount !== 4'd8) begin errors++; $display("FAIL lus_cnt: got %0d want 8", bus.stallCount); end
  endtask

  task automatic test_timeout_and_sat();
    tick(); bus.clrCount = 1'b1;
    tick(); bus.clrCount = 1'b0; bus.memBusy = 1'b1;
    tick(); bus.memBusy = 1'b0;
    tick(); tick(); tick(); // 4th MEM_WAIT cycle
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL to_w4_err: got %b want 0", bus.err); end
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", bus.err); end
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL to_err_en: got %b want %b", en, 7'b0000000); end
    checks++; if (bus.stallCount !== 4'd5) begin errors++; $display("FAIL to_cnt: got %0d want 5", bus.stallCount); end
    bus.memDone = 1'b1;
    tick(); bus.memDone = 1'b0;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", bus.err); end
    for (int i = 0; i < 9; i++) tick();
    checks++; if (bus.stallCount !== 4'd15) begin errors++; $display("FAIL sat_max: got %0d want 15", bus.stallCount); end
    tick();
    checks++; if (bus.stallCount !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", bus.stallCount); end
    bus.clrCount = 1'b1;
    tick(); bus.clrCount = 1'b0;
    checks++; if (bus.stallCount !== 4'd0) begin errors++; $display("FAIL sat_clr: got %0d want 0", bus.stallCount); end
    tick();
    checks++; if (bus.stallCount !== 4'd1) begin errors++; $display("FAIL clr_resume: got %0d want 1", bus.stallCount); end
    #1 rst = 1'b1; #1;
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_async_clr: got %b want 0", bus.err); end
    #1 rst = 1'b0; #2;
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL err_rst_run: got %b want %b", en, 7'b1111100); end
  endtask

  task automatic test_async_reset();
    tick(); bus.memBusy = 1'b1;
    tick(); bus.memBusy = 1'b0; // MEM_WAIT
    #2 rst = 1'b1; #1;
    checks++; if (en !== 7'b0000000) begin errors++; $display("FAIL arst_en: got %b want %b", en, 7'b0000000); end
    checks++; if (bus.stallCount !== 4'd0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", bus.stallCount); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL arst_err: got %b want 0", bus.err); end
    #1 rst = 1'b0; #1;
    checks++; if (en !== 7'b1111100) begin errors++; $display("FAIL arst_run_en: got %b want %b", en, 7'b1111100); end
    tick();
    checks++; if (bus.stallCount !== 4'd0) begin errors++; $display("FAIL arst_after_cnt: got %0d want 0", bus.stallCount); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_mem_wait();
    test_lu_then_mem();
    test_timeout_and_sat();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the five-stage WISC-SP13 core. It sits beside the forwarding logic and handles every hazard that forwarding cannot resolve:
- load-use hazards, with a one-cycle bubble;
- taken-branch flushes;
- multi-cycle data-memory waits, with a timeout watchdog.

It drives the write enables of the PC and all pipeline registers, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MAX_WAIT, 64: maximum consecutive MEM_WAIT cycles before the error state; legal range 2..65535.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IFIDInstr  in  16  instruction in decode; Rs = [10:8], Rt = [7:5].
- IFIDUsesRs  in  1  the decode instruction reads Rs.
- IFIDUsesRt  in  1  the decode instruction reads Rt.
- IDEXMemRead  in  1  the instruction in EX is a load.
- IDEXWriteToReg  in  1  the instruction in EX writes a register.
- IDEXRd  in  3  destination register of the instruction in EX.
- branchTaken  in  1  a branch or jump resolved taken in EX this cycle.
- memBusy  in  1  data memory requests a stall.
- memDone  in  1  data memory access completes this cycle.
- clrCount  in  1  synchronous clear of stallCount.
- pcWrite  out  1  PC register write enable.
- ifidWrite  out  1  IF/ID register write enable.
- idexWrite  out  1  ID/EX register write enable.
- xmWrite  out  1  EX/MEM register write enable.
- mwWrite  out  1  MEM/WB register write enable.
- flushIFID  out  1  load a NOP into IF/ID.
- bubbleIDEX  out  1  load a NOP (all control bits 0) into ID/EX.
- err  out  1  sticky memory-timeout error.
- stallCount  out  CNT_W  saturating count of cycles with pcWrite = 0.

## Operation
- States: RUN, LU_STALL, MEM_WAIT, ERR. The encoding is 2 bits; the state type lives in the package.
- Load-use hazard (lu) = IDEXMemRead & IDEXWriteToReg & ((IFIDUsesRs & IDEXRd == Rs) | (IFIDUsesRt & IDEXRd == Rt)).
- Priority within a cycle: rst > ERR > memBusy > branchTaken > lu.
- RUN:
  - With no event, all five write enables are 1 and flush/bubble are 0.
  - memBusy: all write enables 0. Next state MEM_WAIT and the wait counter loads 1.
  - branchTaken (with memBusy = 0): flushIFID = 1 and bubbleIDEX = 1; all write enables stay 1 so the PC redirects. lu is ignored. Stay in RUN.
  - lu (with no higher-priority event): pcWrite = 0, ifidWrite = 0, bubbleIDEX = 1; the other write enables are 1. Next state LU_STALL.
- LU_STALL:
  - lu is not re-evaluated, because ID/EX holds a bubble.
  - With no event, all write enables are 1. Next state RUN.
  - memBusy or branchTaken are handled exactly as in RUN, but the next state is RUN or MEM_WAIT.
- MEM_WAIT:
  - All write enables are 0; flush and bubble are 0.
  - memDone: next state RUN, and the counter clears. memDone wins over the timeout in the same cycle.
  - Otherwise, if the counter == MAX_WAIT, next state ERR.
  - Otherwise the counter increments.
  - branchTaken is ignored, because EX is frozen and the branch is re-presented after the wait.
- ERR: all write enables 0 and err = 1. The state is left only through rst.
- stallCount:
  - Increments in every cycle where pcWrite = 0 and rst = 0.
  - Saturates at 2^CNT_W - 1.
  - clrCount forces the next value to 0 and takes priority over the increment.
- Outputs other than stallCount and err are combinational from the state and current inputs (Mealy).

## Timing
- Reset values: state = RUN, wait counter = 0, stallCount = 0, err = 0.
- While rst = 1, all write enables, flushIFID and bubbleIDEX are forced to 0.
- Hazard response has zero latency: the enables react in the same cycle as the hazard inputs.
- Load-use costs exactly one stall cycle per hazard.
- Branch flush costs two squashed instructions and no stall cycle.
- Memory wait of N cycles (memBusy first high, memDone after N-1 further cycles): pcWrite is low for N+1 cycles (the memBusy cycle plus N MEM_WAIT cycles).
- Timeout: err rises in the cycle after the MAX_WAIT-th MEM_WAIT cycle without memDone.
- rst asserted mid-MEM_WAIT or mid-LU_STALL returns the state to RUN immediately and asynchronously. The pipeline contents are not this block's concern.

## Structure
- Shared package `hazard_pkg`:
  - the state typedef with RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2, ERR = 2'd3;
  - the Rs/Rt field bit positions.
- One sub-module, `hazard_cmp`: the combinational lu compare, reused by the verification scoreboard.
- The FSM, wait counter and stall counter stay in the top module.

## Test plan
- Load-use: EX holds a load with IDEXRd = 3, decode reads Rs = 3 -> one cycle of pcWrite = ifidWrite = 0 and bubbleIDEX = 1, then all enables 1; stallCount = 1.
- Priority: lu and branchTaken in the same cycle -> flushIFID = bubbleIDEX = 1, pcWrite = 1, no stall; stallCount unchanged.
- Memory wait: memBusy for 1 cycle, then memDone 4 cycles later -> pcWrite low for 5 cycles, then RUN; stallCount = 5.
- Timeout: MAX_WAIT = 4, memBusy with memDone never asserted -> err = 1 after the 4th MEM_WAIT cycle and stays high until rst; memDone in the same cycle as the limit -> RUN, err = 0.
- Async reset: assert rst mid-MEM_WAIT between clock edges -> all enables 0 at once and err = 0; after release, state RUN with all enables 1.
- Counter: force 2^CNT_W - 1 stall cycles then one more -> stallCount holds at all-ones; clrCount together with a stall -> 0.
